iter_div_unit: RTL and testbench

Parametrised, handshaked iterative restoring divider for the CPU execute stage. It computes a WIDTH-bit quotient and remainder, signed or unsigned, one quotient bit per cycle. It adds over the previous fixed 32-bit divider:
- valid/ready handshakes on input and output,
- a pass-through tag,
- a cancel/flush path,
- a defined divide-by-zero result with flag.

---
 rtl/iter_div_unit.sv | 173 +++++++++++++++++
 tb/tb_iter_div_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_unit.sv
// Iterative restoring divider for the execute stage.
// Produces one quotient bit per cycle behind valid/ready handshakes. The
// request tag is carried through to the result. A cancel input flushes the
// operation in flight, and divide-by-zero gives a defined result with a flag.
module iter_div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   origX_q, origX_d;
  logic               qSign_q, qSign_d;
  logic               rSign_q, rSign_d;
  logic               dbz_q, dbz_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   outQ_q, outQ_d;
  logic [WIDTH-1:0]   outR_q, outR_d;
  logic [TAG_W-1:0]   outTag_q, outTag_d;
  logic               outDbz_q, outDbz_d;

  logic               xNeg, yNeg;
  logic [WIDTH-1:0]   absX, absY;
  logic [WIDTH:0]     shifted, trial;

  // Next-state logic: accept, one restoring step per cycle, sign fix-up, output handshake
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divisor_d   = divisor_q;
    origX_d     = origX_q;
    qSign_d     = qSign_q;
    rSign_d     = rSign_q;
    dbz_d       = dbz_q;
    tag_d       = tag_q;
    outQ_d      = outQ_q;
    outR_d      = outR_q;
    outTag_d    = outTag_q;
    outDbz_d    = outDbz_q;

    xNeg    = in_signed & in_x[WIDTH-1];
    yNeg    = in_signed & in_y[WIDTH-1];
    absX    = (in_x ^ {WIDTH{xNeg}}) + {{(WIDTH-1){1'b0}}, xNeg};
    absY    = (in_y ^ {WIDTH{yNeg}}) + {{(WIDTH-1){1'b0}}, yNeg};
    shifted = {remainder_q, quotient_q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_q};

    if (cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            quotient_d  = absX;
            remainder_d = '0;
            divisor_d   = absY;
            origX_d     = in_x;
            qSign_d     = xNeg ^ (in_signed & in_y[WIDTH-1]);
            rSign_d     = xNeg;
            dbz_d       = (in_y == '0);
            tag_d       = in_tag;
            count_d     = '0;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (count_q != LAST_CNT) begin
            if (!trial[WIDTH]) begin
              remainder_d = trial[WIDTH-1:0];
              quotient_d  = {quotient_q[WIDTH-2:0], 1'b1};
            end else begin
              remainder_d = shifted[WIDTH-1:0];
              quotient_d  = {quotient_q[WIDTH-2:0], 1'b0};
            end
            count_d = count_q + 1'b1;
          end else begin
            if (dbz_q) begin
              outQ_d = '1;
              outR_d = origX_q;
            end else begin
              outQ_d = qSign_q ? -quotient_q : quotient_q;
              outR_d = rSign_q ? -remainder_q : remainder_q;
            end
            outTag_d = tag_q;
            outDbz_d = dbz_q;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge div_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divisor_q   <= '0;
      origX_q     <= '0;
      qSign_q     <= 1'b0;
      rSign_q     <= 1'b0;
      dbz_q       <= 1'b0;
      tag_q       <= '0;
      outQ_q      <= '0;
      outR_q      <= '0;
      outTag_q    <= '0;
      outDbz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divisor_q   <= divisor_d;
      origX_q     <= origX_d;
      qSign_q     <= qSign_d;
      rSign_q     <= rSign_d;
      dbz_q       <= dbz_d;
      tag_q       <= tag_d;
      outQ_q      <= outQ_d;
      outR_q      <= outR_d;
      outTag_q    <= outTag_d;
      outDbz_q    <= outDbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_q     = outQ_q;
  assign out_r     = outR_q;
  assign out_tag   = outTag_q;
  assign out_dbz   = outDbz_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit at WIDTH 32 and WIDTH 8.
// Expected results come from an arithmetic reference model. They are queued
// when a request is accepted and compared when the result handshake occurs.
module tb_iter_div_unit;

  localparam int TAG_W = 5;

  logic div_clk = 1'b0;
  logic reset, cancel;

  logic        inValid32, inReady32, inSigned32, outValid32, outReady32, outDbz32, busy32;
  logic [31:0] inX32, inY32, outQ32, outR32;
  logic [4:0]  inTag32, outTag32;

  logic        inValid8, inReady8, inSigned8, outValid8, outReady8, outDbz8, busy8;
  logic [7:0]  inX8, inY8, outQ8, outR8;
  logic [4:0]  inTag8, outTag8;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [4:0]  tag;
    logic        dbz;
  } exp_t;

  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Free-running clock
  always #5 div_clk = ~div_clk;

  iter_div_unit #(.WIDTH(32), .TAG_W(TAG_W)) dut32 (
    .div_clk(div_clk), .reset(reset), .cancel(cancel),
    .in_valid(inValid32), .in_ready(inReady32), .in_signed(inSigned32),
    .in_x(inX32), .in_y(inY32), .in_tag(inTag32),
    .out_valid(outValid32), .out_ready(outReady32),
    .out_q(outQ32), .out_r(outR32), .out_tag(outTag32),
    .out_dbz(outDbz32), .busy(busy32)
  );

  iter_div_unit #(.WIDTH(8), .TAG_W(TAG_W)) dut8 (
    .div_clk(div_clk), .reset(reset), .cancel(cancel),
    .in_valid(inValid8), .in_ready(inReady8), .in_signed(inSigned8),
    .in_x(inX8), .in_y(inY8), .in_tag(inTag8),
    .out_valid(outValid8), .out_ready(outReady8),
    .out_q(outQ8), .out_r(outR8), .out_tag(outTag8),
    .out_dbz(outDbz8), .busy(busy8)
  );

  function automatic exp_t model(int w, bit s, logic [31:0] x, logic [31:0] y, logic [4:0] tag);
    exp_t   e;
    longint mask, sx, sy, q, r;
    mask = (longint'(1) << w) - 1;
    if (y == 32'd0) begin
      q = mask;
      r = longint'(x);
    end else if (s) begin
      sx = x[w-1] ? (longint'(x) | ~mask) : longint'(x);
      sy = y[w-1] ? (longint'(y) | ~mask) : longint'(y);
      q  = sx / sy;
      r  = sx % sy;
    end else begin
      q = longint'(x) / longint'(y);
      r = longint'(x) % longint'(y);
    end
    e.q   = 32'(q & mask);
    e.r   = 32'(r & mask);
    e.tag = tag;
    e.dbz = (y == 32'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] observed, logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", name, observed, expected);
    end
  endtask

  task automatic sampleOut(input int w, output logic v, output logic rdy, output logic [31:0] q,
                           output logic [31:0] r, output logic [4:0] tg, output logic dbz);
    if (w == 32) begin
      v = outValid32; rdy = inReady32; q = outQ32; r = outR32; tg = outTag32; dbz = outDbz32;
    end else begin
      v = outValid8; rdy = inReady8; q = {24'd0, outQ8}; r = {24'd0, outR8}; tg = outTag8; dbz = outDbz8;
    end
  endtask

  // Drive one request on the selected instance; queue the model result when push is set
  task automatic applyStimulus(int w, bit s, logic [31:0] x, logic [31:0] y, logic [4:0] tag, bit push);
    logic v, rdy, dbz;
    logic [31:0] q, r;
    logic [4:0] tg;
    int waitCycles = 0;
    sampleOut(w, v, rdy, q, r, tg, dbz);
    while (!rdy && waitCycles < 100) begin
      tick();
      waitCycles++;
      sampleOut(w, v, rdy, q, r, tg, dbz);
    end
    checkOutput("in_ready_before_request", {31'd0, rdy}, 32'd1);
    if (w == 32) begin
      inValid32 = 1'b1; inSigned32 = s; inX32 = x; inY32 = y; inTag32 = tag;
    end else begin
      inValid8 = 1'b1; inSigned8 = s; inX8 = x[7:0]; inY8 = y[7:0]; inTag8 = tag;
    end
    if (push) sbQueue.push_back(model(w, s, x, y, tag));
    tick();
    inValid32 = 1'b0; inValid8 = 1'b0;
    inX32 = 32'hDEADBEEF; inY32 = 32'h0BADF00D; inX8 = 8'hA5; inY8 = 8'h3C;
  endtask

  // Wait for the result, check latency, hold under backpressure, then complete the handshake
  task automatic awaitResult(int w, int expLat, int holdCycles);
    logic v, rdy, dbz;
    logic [31:0] q, r;
    logic [4:0] tg;
    exp_t e;
    int lat = 0;
    sampleOut(w, v, rdy, q, r, tg, dbz);
    while (!v && lat < 100) begin
      tick();
      lat++;
      sampleOut(w, v, rdy, q, r, tg, dbz);
    end
    checkOutput("latency", lat, expLat);
    checkOutput("scoreboard_nonempty", {31'd0, (sbQueue.size() != 0)}, 32'd1);
    if (sbQueue.size() == 0) return;
    e = sbQueue.pop_front();
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("hold_out_valid", {31'd0, v}, 32'd1);
      checkOutput("hold_in_ready", {31'd0, rdy}, 32'd0);
      checkOutput("hold_out_q", q, e.q);
      checkOutput("hold_out_r", r, e.r);
      tick();
      sampleOut(w, v, rdy, q, r, tg, dbz);
    end
    checkOutput("out_q", q, e.q);
    checkOutput("out_r", r, e.r);
    checkOutput("out_tag", {27'd0, tg}, {27'd0, e.tag});
    checkOutput("out_dbz", {31'd0, dbz}, {31'd0, e.dbz});
    if (w == 32) outReady32 = 1'b1; else outReady8 = 1'b1;
    tick();
    outReady32 = 1'b0; outReady8 = 1'b0;
    sampleOut(w, v, rdy, q, r, tg, dbz);
    checkOutput("in_ready_after_handshake", {31'd0, rdy}, 32'd1);
    checkOutput("out_valid_after_handshake", {31'd0, v}, 32'd0);
  endtask

  task automatic watchNoResult(string name);
    logic sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      sawValid = sawValid | outValid32;
    end
    checkOutput(name, {31'd0, sawValid}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; cancel = 1'b0;
    inValid32 = 1'b0; inSigned32 = 1'b0; inX32 = '0; inY32 = '0; inTag32 = '0; outReady32 = 1'b0;
    inValid8 = 1'b0; inSigned8 = 1'b0; inX8 = '0; inY8 = '0; inTag8 = '0; outReady8 = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    checkOutput("reset_in_ready", {31'd0, inReady32}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, outValid32}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy32}, 32'd0);
    checkOutput("reset_out_q", outQ32, 32'd0);
    checkOutput("reset_out_r", outR32, 32'd0);
    checkOutput("reset_out_tag", {27'd0, outTag32}, 32'd0);
    checkOutput("reset_out_dbz", {31'd0, outDbz32}, 32'd0);
    checkOutput("reset_in_ready8", {31'd0, inReady8}, 32'd1);

    applyStimulus(32, 1'b0, 32'd100, 32'd7, 5'd3, 1'b1);
    checkOutput("busy_after_accept", {31'd0, busy32}, 32'd1);
    checkOutput("in_ready_after_accept", {31'd0, inReady32}, 32'd0);
    awaitResult(32, 33, 0);

    applyStimulus(32, 1'b1, -32'sd7, 32'd2, 5'd4, 1'b1);
    awaitResult(32, 33, 0);
    applyStimulus(32, 1'b1, 32'd7, -32'sd2, 5'd5, 1'b1);
    awaitResult(32, 33, 0);
    applyStimulus(32, 1'b1, -32'sd7, -32'sd2, 5'd6, 1'b1);
    awaitResult(32, 33, 0);

    applyStimulus(32, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b1);
    awaitResult(32, 33, 0);
    applyStimulus(32, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd8, 1'b1);
    awaitResult(32, 33, 0);

    applyStimulus(32, 1'b1, 32'h12345678, 32'd0, 5'd9, 1'b1);
    awaitResult(32, 33, 0);
    applyStimulus(32, 1'b0, 32'h12345678, 32'd0, 5'd10, 1'b1);
    awaitResult(32, 33, 0);

    applyStimulus(32, 1'b0, 32'd12345, 32'd67, 5'd11, 1'b1);
    awaitResult(32, 33, 10);
    applyStimulus(32, 1'b0, 32'd1000, 32'd10, 5'd12, 1'b1);
    awaitResult(32, 33, 0);

    applyStimulus(32, 1'b0, 32'd5000, 32'd3, 5'd13, 1'b0);
    repeat (5) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checkOutput("cancel_in_ready", {31'd0, inReady32}, 32'd1);
    checkOutput("cancel_busy", {31'd0, busy32}, 32'd0);
    watchNoResult("cancel_no_result");

    applyStimulus(32, 1'b1, 32'd5000, 32'd3, 5'd14, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset_abort_in_ready", {31'd0, inReady32}, 32'd1);
    checkOutput("reset_abort_out_q", outQ32, 32'd0);
    watchNoResult("reset_abort_no_result");

    inValid32 = 1'b1; inSigned32 = 1'b0; inX32 = 32'd77; inY32 = 32'd7; inTag32 = 5'd15;
    cancel = 1'b1;
    tick();
    inValid32 = 1'b0;
    cancel = 1'b0;
    checkOutput("cancel_with_valid_busy", {31'd0, busy32}, 32'd0);
    checkOutput("cancel_with_valid_in_ready", {31'd0, inReady32}, 32'd1);
    watchNoResult("cancel_with_valid_no_result");

    applyStimulus(32, 1'b0, 32'hFFFFFFFF, 32'd16, 5'd16, 1'b1);
    awaitResult(32, 33, 0);

    applyStimulus(8, 1'b0, 32'd100, 32'd7, 5'd17, 1'b1);
    awaitResult(8, 9, 0);
    applyStimulus(8, 1'b1, 32'h5A, 32'd0, 5'd18, 1'b1);
    awaitResult(8, 9, 0);
    applyStimulus(8, 1'b0, 32'h5A, 32'd0, 5'd19, 1'b1);
    awaitResult(8, 9, 0);
    applyStimulus(8, 1'b1, 32'hF9, 32'h02, 5'd20, 1'b1);
    awaitResult(8, 9, 0);
    applyStimulus(8, 1'b1, 32'h80, 32'hFF, 5'd21, 1'b1);
    awaitResult(8, 9, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
